// File: rtl/tff_bank_debounced.sv
// rtl/tff_bank_debounced.sv - bank of debounced push-button toggle flip-flops
// Each channel: 2-flop synchroniser, counter debouncer, press detector, mode-selectable q register.
module tff_bank_debounced #(
  parameter int                    CHANNELS        = 4,
  parameter int                    DEBOUNCE_CYCLES = 16,
  parameter logic [CHANNELS-1:0]   RESET_Q         = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] btn,
  input  logic [CHANNELS-1:0] clr,
  input  logic [CHANNELS-1:0] pre,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_n,
  output logic [CHANNELS-1:0] press_pulse
);

  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_SET     = 2'b01,
    MODE_FOLLOW  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] s1, s2;
  logic [CHANNELS-1:0] db, db_nxt;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] q_nxt;
  logic [CW-1:0]       cnt     [CHANNELS];
  logic [CW-1:0]       cnt_nxt [CHANNELS];
  mode_t               mode_sel;

  assign mode_sel = mode_t'(mode);

  always_comb begin
    db_nxt = db;
    rise   = '0;
    q_nxt  = q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != db[i]) begin
        if (cnt[i] == LAST) begin
          db_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
      // A press is the debounced level rising on this edge.
      rise[i] = ~db[i] & db_nxt[i];

      if (clr[i]) begin
        q_nxt[i] = 1'b0;
      end else if (pre[i]) begin
        q_nxt[i] = 1'b1;
      end else if (en) begin
        case (mode_sel)
          MODE_TOGGLE:  q_nxt[i] = rise[i] ? ~q[i] : q[i];
          MODE_SET:     q_nxt[i] = rise[i] ? 1'b1 : q[i];
          MODE_FOLLOW:  q_nxt[i] = db_nxt[i];
          MODE_ONESHOT: q_nxt[i] = rise[i];
          default:      q_nxt[i] = q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      db          <= '0;
      press_pulse <= '0;
      q           <= RESET_Q;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= btn;
      s2          <= s1;
      db          <= db_nxt;
      press_pulse <= rise;
      q           <= q_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_tff_bank_debounced.sv
// tb/tb_tff_bank_debounced.sv - directed self-checking bench for tff_bank_debounced
module tb_tff_bank_debounced;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] btn, clr, pre;
  logic [3:0] q, q_n, press_pulse;

  int checks   = 0;
  int failures = 0;
  int pulses;

  tff_bank_debounced #(
    .CHANNELS       (4),
    .DEBOUNCE_CYCLES(4),
    .RESET_Q        (4'b0101)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .btn        (btn),
    .clr        (clr),
    .pre        (pre),
    .q          (q),
    .q_n        (q_n),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, counting cycles where press_pulse[ch] is high.
  task automatic run(input int n, input int ch, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (press_pulse[ch]) cnt++;
    end
  endtask

  task automatic test_reset();
    int early;
    rst = 1'b1; en = 1'b0; mode = 2'b00; btn = 4'b1111; clr = '0; pre = '0;
    tick(); tick();
    checks++;
    if (q !== 4'b0101) begin failures++; $display("FAIL reset_q got=%b exp=%b", q, 4'b0101); end
    checks++;
    if (q_n !== 4'b1010) begin failures++; $display("FAIL reset_qn got=%b exp=%b", q_n, 4'b1010); end
    checks++;
    if (press_pulse !== 4'b0000) begin failures++; $display("FAIL reset_pp got=%b exp=%b", press_pulse, 4'b0000); end
    rst = 1'b0;
    early = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (press_pulse !== 4'b0000) early++;
    end
    checks++;
    if (early !== 0) begin failures++; $display("FAIL reset_early_pp got=%0d exp=0", early); end
    tick();
    checks++;
    if (press_pulse !== 4'b1111) begin failures++; $display("FAIL reset_pp_edge5 got=%b exp=%b", press_pulse, 4'b1111); end
    checks++;
    if (q !== 4'b0101) begin failures++; $display("FAIL reset_q_hold got=%b exp=%b", q, 4'b0101); end
    tick();
    checks++;
    if (press_pulse !== 4'b0000) begin failures++; $display("FAIL reset_pp_one_cycle got=%b exp=%b", press_pulse, 4'b0000); end
    btn = 4'b0000;
    run(8, 0, pulses);
    clr = 4'b1111; tick(); clr = 4'b0000;
    en = 1'b1; mode = 2'b00;
    checks++;
    if (q !== 4'b0000) begin failures++; $display("FAIL clr_all got=%b exp=%b", q, 4'b0000); end
  endtask

  task automatic test_toggle();
    btn[0] = 1'b1;
    run(5, 0, pulses);
    checks++;
    if (q[0] !== 1'b0) begin failures++; $display("FAIL toggle_before got=%b exp=0", q[0]); end
    tick();
    checks++;
    if (q !== 4'b0001 || press_pulse !== 4'b0001) begin
      failures++; $display("FAIL toggle_edge5 got q=%b pp=%b exp q=0001 pp=0001", q, press_pulse);
    end
    run(8, 0, pulses);
    checks++;
    if (pulses !== 0 || q[0] !== 1'b1) begin
      failures++; $display("FAIL toggle_hold got pulses=%0d q0=%b exp pulses=0 q0=1", pulses, q[0]);
    end
    btn[0] = 1'b0;
    run(8, 0, pulses);
    checks++;
    if (pulses !== 0 || q[0] !== 1'b1) begin
      failures++; $display("FAIL toggle_release got pulses=%0d q0=%b exp pulses=0 q0=1", pulses, q[0]);
    end
    btn[0] = 1'b1;
    run(6, 0, pulses);
    checks++;
    if (pulses !== 1 || q[0] !== 1'b0) begin
      failures++; $display("FAIL toggle_second got pulses=%0d q0=%b exp pulses=1 q0=0", pulses, q[0]);
    end
    btn[0] = 1'b0;
    run(8, 0, pulses);
  endtask

  task automatic test_bounce();
    btn[1] = 1'b1;
    tick(); tick(); tick();
    btn[1] = 1'b0;
    run(12, 1, pulses);
    checks++;
    if (pulses !== 0 || q[1] !== 1'b0) begin
      failures++; $display("FAIL bounce_short got pulses=%0d q1=%b exp pulses=0 q1=0", pulses, q[1]);
    end
    btn[1] = 1'b1;
    run(4, 1, pulses);
    btn[1] = 1'b0;
    begin
      int more;
      run(14, 1, more);
      pulses += more;
    end
    checks++;
    if (pulses !== 1 || q[1] !== 1'b1) begin
      failures++; $display("FAIL bounce_4cyc got pulses=%0d q1=%b exp pulses=1 q1=1", pulses, q[1]);
    end
  endtask

  task automatic test_priority();
    btn[2] = 1'b1;
    run(5, 2, pulses);
    clr[2] = 1'b1; pre[2] = 1'b1;
    tick();
    clr[2] = 1'b0; pre[2] = 1'b0;
    checks++;
    if (q[2] !== 1'b0 || press_pulse[2] !== 1'b1) begin
      failures++; $display("FAIL prio_clr_pre got q2=%b pp2=%b exp q2=0 pp2=1", q[2], press_pulse[2]);
    end
    en = 1'b0; pre[2] = 1'b1;
    tick();
    pre[2] = 1'b0;
    checks++;
    if (q[2] !== 1'b1) begin failures++; $display("FAIL prio_pre_en0 got=%b exp=1", q[2]); end
    btn[2] = 1'b0;
    run(8, 2, pulses);
    clr[2] = 1'b1; tick(); clr[2] = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_enable();
    en = 1'b0;
    btn[3] = 1'b1;
    run(10, 3, pulses);
    checks++;
    if (pulses !== 1 || q[3] !== 1'b0) begin
      failures++; $display("FAIL en0_press got pulses=%0d q3=%b exp pulses=1 q3=0", pulses, q[3]);
    end
    en = 1'b1;
    run(5, 3, pulses);
    checks++;
    if (q[3] !== 1'b0) begin failures++; $display("FAIL en_no_delayed got=%b exp=0", q[3]); end
    btn[3] = 1'b0;
    run(8, 3, pulses);
  endtask

  task automatic test_modes();
    mode = 2'b10;
    btn[0] = 1'b1;
    run(5, 0, pulses);
    checks++;
    if (q[0] !== 1'b0) begin failures++; $display("FAIL follow_rise_early got=%b exp=0", q[0]); end
    tick();
    checks++;
    if (q[0] !== 1'b1) begin failures++; $display("FAIL follow_rise got=%b exp=1", q[0]); end
    run(3, 0, pulses);
    btn[0] = 1'b0;
    run(5, 0, pulses);
    checks++;
    if (q[0] !== 1'b1) begin failures++; $display("FAIL follow_fall_early got=%b exp=1", q[0]); end
    tick();
    checks++;
    if (q[0] !== 1'b0) begin failures++; $display("FAIL follow_fall got=%b exp=0", q[0]); end

    mode = 2'b01;
    for (int p = 0; p < 2; p++) begin
      btn[0] = 1'b1;
      run(6, 0, pulses);
      btn[0] = 1'b0;
      run(8, 0, pulses);
    end
    checks++;
    if (q[0] !== 1'b1) begin failures++; $display("FAIL set_two_presses got=%b exp=1", q[0]); end

    mode = 2'b11;
    btn[0] = 1'b1;
    run(5, 0, pulses);
    checks++;
    if (q[0] !== 1'b0) begin failures++; $display("FAIL oneshot_idle got=%b exp=0", q[0]); end
    tick();
    checks++;
    if (q[0] !== 1'b1 || press_pulse[0] !== 1'b1) begin
      failures++; $display("FAIL oneshot_pulse got q0=%b pp0=%b exp q0=1 pp0=1", q[0], press_pulse[0]);
    end
    tick();
    checks++;
    if (q[0] !== 1'b0) begin failures++; $display("FAIL oneshot_end got=%b exp=0", q[0]); end
    btn[0] = 1'b0;
    run(8, 0, pulses);
  endtask

  task automatic test_back_to_back();
    mode = 2'b00; en = 1'b1;
    clr = 4'b1111; tick(); clr = 4'b0000;
    btn = 4'b1111;
    run(6, 0, pulses);
    checks++;
    if (q !== 4'b1111 || press_pulse !== 4'b1111 || q_n !== 4'b0000) begin
      failures++; $display("FAIL multi_press got q=%b pp=%b qn=%b exp q=1111 pp=1111 qn=0000", q, press_pulse, q_n);
    end
    btn = 4'b0000;
    run(8, 0, pulses);
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_bounce();
    test_priority();
    test_enable();
    test_modes();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
